// File: rtl/fetch_decode_hazard_ctrl.sv
// IF/ID + PC hazard control: load-use, taken-branch flush, mult/div stall.
// Optional stall counter output guarded by HAZARD_STATS_EN.
module fetch_decode_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRs,
  input  logic        IDUsesRt,
  input  logic        IDMulDiv,
  input  logic        EXMemRead,
  input  logic [4:0]  EXRt,
  input  logic        EXBranchTaken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXBubble,
`ifdef HAZARD_STATS_EN
  output logic        MulDivBusy,
  output logic [31:0] StallCount
`else
  output logic        MulDivBusy
`endif
);

  typedef enum logic {RUN, MDBUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_lu;
  logic             w_busy;

  assign w_busy = (r_state == MDBUSY);

  assign w_lu = EXMemRead && (EXRt != 5'd0) &&
                ((IDUsesRs && (IDRs == EXRt)) ||
                 (IDUsesRt && (IDRt == EXRt)));

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    MulDivBusy = w_busy && Reset;
    if (!Reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (EXBranchTaken) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (w_busy || w_lu) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end
  end

  // A flushed or load-stalled mult/div must not start the countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_busy) begin
      w_cnt_nxt = r_cnt - 1'b1;
      if (r_cnt <= CNT_W'(1))
        w_state_nxt = RUN;
    end else if (!EXBranchTaken && !w_lu && IDMulDiv) begin
      w_cnt_nxt   = CNT_W'(MULDIV_CYCLES - 1);
      w_state_nxt = MDBUSY;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      r_stall_cnt <= '0;
    else if (!IFIDWrite)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign StallCount = r_stall_cnt;
`endif

endmodule

// File: doc/fetch_decode_hazard_ctrl.md
# fetch_decode_hazard_ctrl

Hazard controller for the Fetch→Decode pipeline register and the PC. Each cycle it decides whether the PC and the IF/ID register load, hold or flush, and whether a bubble goes into ID/EX. It detects load-use hazards, taken-branch redirects and structural stalls behind a multi-cycle mult/div. It sits beside the IF/ID and ID/EX registers and drives their write-enable and flush controls.

## Interface
- MULDIV_CYCLES, 4: EX occupancy of a mult/div in cycles; legal range 2..15.
- CNT_W, 4: width of the mult/div countdown counter; must hold MULDIV_CYCLES-1.

- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IDRs  in  5  rs field of the instruction in ID.
- IDRt  in  5  rt field of the instruction in ID.
- IDUsesRs  in  1  the ID instruction reads rs.
- IDUsesRt  in  1  the ID instruction reads rt.
- IDMulDiv  in  1  the ID instruction is mult/multu/div/divu.
- EXMemRead  in  1  the instruction in EX is a load.
- EXRt  in  5  destination register of the load in EX.
- EXBranchTaken  in  1  the branch or jump in EX is taken; PC redirect is in progress.
- PCWrite  out  1  PC loads its next value.
- IFIDWrite  out  1  IF/ID register loads.
- IFIDFlush  out  1  IF/ID loads a NOP (0x00000000) instead of the fetched instruction.
- IDEXBubble  out  1  ID/EX loads all-zero control signals.
- MulDivBusy  out  1  high while in state MDBUSY.
- StallCount  out  32  number of stall cycles; present only with HAZARD_STATS_EN.

## Operation
- States: RUN and MDBUSY. MDCnt is a CNT_W-bit countdown counter.
- Outputs are Mealy: combinational from state and the current inputs.
- LoadUse = EXMemRead & (EXRt != 0) & ((IDUsesRs & IDRs == EXRt) | (IDUsesRt & IDRt == EXRt)).
- Priority in every state: flush, then MDBUSY stall, then load-use, then mult/div issue, then normal.

**Flush** (EXBranchTaken = 1)
- Outputs: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=1.
- A flushed IDMulDiv is ignored: no transition to MDBUSY.
- In MDBUSY, MDCnt keeps counting.

**MDBUSY stall**
- Outputs: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=1.
- MDCnt decrements each cycle.
- When MDCnt == 1, the next state is RUN.

**Load-use** (RUN)
- Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
- State stays RUN. The hazard clears once the load reaches MEM, so exactly one stall cycle results.

**Mult/div issue** (RUN, IDMulDiv = 1, no higher-priority condition)
- Outputs are normal, so the mult/div advances into EX.
- MDCnt <= MULDIV_CYCLES-1; next state is MDBUSY.

**Normal**
- Outputs: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.

**Reset** (Reset low, asynchronous)
- State = RUN, MDCnt = 0, StallCount = 0.
- Outputs forced: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, MulDivBusy=0.
- A reset in the middle of MDBUSY aborts the count immediately.

## Timing
- Zero-cycle decision: outputs respond combinationally in the same cycle as the inputs. The pipeline registers sample the outputs on the next rising Clk.
- One load-use hazard yields exactly 1 stall cycle.
- One mult/div yields exactly MULDIV_CYCLES-1 stall cycles, starting the cycle after issue.
- Flush costs 1 cycle; the NOP occupies IF/ID.
- Reset release is synchronous-safe: the first rising edge with Reset high evaluates normal RUN logic.

## Configuration
- HAZARD_STATS_EN defined:
  - StallCount port exists.
  - StallCount increments on each rising Clk where Reset is high and IFIDWrite == 0.
  - It wraps 0xFFFFFFFF → 0.
  - It clears only on reset.
- HAZARD_STATS_EN undefined: the StallCount port and its register are omitted; all other behaviour is identical.

## Test plan
- Load-use: EXMemRead=1, EXRt=8, IDRs=8, IDUsesRs=1 for one cycle.
  - Same cycle: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - Next cycle, with EXMemRead=0: all outputs normal.
- $zero filter: EXMemRead=1, EXRt=0, IDRs=0, IDUsesRs=1 → no stall. Same stimulus with IDUsesRs=0 and IDRs=8=EXRt → no stall.
- Mult/div with MULDIV_CYCLES=4: IDMulDiv=1 in RUN.
  - Issue cycle: outputs normal.
  - Next 3 cycles: MulDivBusy=1, PCWrite=0, IDEXBubble=1.
  - 4th cycle: state is RUN.
- Branch over mult/div: EXBranchTaken=1 and IDMulDiv=1 together → IFIDFlush=1, IDEXBubble=1, PCWrite=1; next state RUN.
- Async reset: drop Reset mid-MDBUSY with no Clk edge.
  - Immediately: MulDivBusy=0, IFIDFlush=1, StallCount=0.
  - After Reset rises and one edge with idle inputs: normal outputs.
- HAZARD_STATS_EN: one load-use stall plus one mult/div with MULDIV_CYCLES=4 → StallCount=4. Preload StallCount to 0xFFFFFFFF and apply one stall → 0.
